// File: rtl/vdp_super_palette.sv
// vdp_super_palette: 256x24 RGB palette RAM with a one-cycle read port, a grey-ramp
// init sweep after reset, and a byte-serial R/G/B CPU write sequencer.
module vdp_super_palette #(
   parameter int INIT_ENTRIES = 256
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] PALETTE_ADDR2,
   output logic [7:0] PALETTE_DATA_R2_OUT,
   output logic [7:0] PALETTE_DATA_G2_OUT,
   output logic [7:0] PALETTE_DATA_B2_OUT,
   input  logic       pal_wr_index_load,
   input  logic [7:0] pal_wr_index,
   input  logic       pal_wr_strobe,
   input  logic [7:0] pal_wr_data,
   output logic       pal_init_busy,
   output logic       pal_commit,
   output logic [7:0] pal_wr_index_out
);
   typedef enum logic {INIT, IDLE} state_t;
   typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;
   state_t state, state_nx;
   phase_t phase;
   logic [7:0] init_cnt, wr_idx, red, grn;
   logic [23:0] ram [256];
   logic [23:0] rd_q, wdata;
   logic [7:0] waddr;
   logic init_last, cpu_load, cpu_strobe, we;
   assign init_last = init_cnt == 8'(INIT_ENTRIES - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= INIT;
      else state <= state_nx;
   always_comb state_nx = (state == INIT && init_last) ? IDLE : state;
   always_comb begin
      pal_init_busy = state == INIT;
      cpu_load = !pal_init_busy && pal_wr_index_load;
      cpu_strobe = !pal_init_busy && !pal_wr_index_load && pal_wr_strobe;
      we = pal_init_busy || (cpu_strobe && phase == PH_B);
      waddr = pal_init_busy ? init_cnt : wr_idx;
      wdata = pal_init_busy ? {3{init_cnt}} : {red, grn, pal_wr_data};
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         init_cnt <= '0;
         wr_idx <= '0;
         phase <= PH_R;
         red <= '0;
         grn <= '0;
         pal_commit <= 1'b0;
      end else begin
         pal_commit <= we;
         if (pal_init_busy) init_cnt <= init_cnt + 8'd1;
         if (cpu_load) begin
            wr_idx <= pal_wr_index;
            phase <= PH_R;
         end else if (cpu_strobe) begin
            phase <= phase == PH_R ? PH_G : phase == PH_G ? PH_B : PH_R;
            if (phase == PH_R) red <= pal_wr_data;
            if (phase == PH_G) grn <= pal_wr_data;
            if (phase == PH_B) wr_idx <= wr_idx + 8'd1;
         end
      end
   // Plain write/read on one clock: a same-address read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (we) ram[waddr] <= wdata;
      rd_q <= ram[PALETTE_ADDR2];
   end
   logic rd_valid;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) rd_valid <= 1'b0;
      else rd_valid <= !pal_init_busy;
   always_comb begin
      PALETTE_DATA_R2_OUT = rd_valid ? rd_q[23:16] : 8'h00;
      PALETTE_DATA_G2_OUT = rd_valid ? rd_q[15:8] : 8'h00;
      PALETTE_DATA_B2_OUT = rd_valid ? rd_q[7:0] : 8'h00;
      pal_wr_index_out = wr_idx;
   end
endmodule

// File: tb/tb_vdp_super_palette.sv
// tb_vdp_super_palette: directed bench with a read scoreboard for the palette RAM stage.
module tb_vdp_super_palette;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [7:0] addr = '0, wr_index = '0, wr_data = '0;
   logic load = 1'b0, strobe = 1'b0;
   logic [7:0] r, g, b, idx_out;
   logic busy, commit;
   int compared = 0, mismatched = 0;
   logic [23:0] exp_q[$];
   vdp_super_palette dut (
      .clk(clk), .reset_n(reset_n), .PALETTE_ADDR2(addr),
      .PALETTE_DATA_R2_OUT(r), .PALETTE_DATA_G2_OUT(g), .PALETTE_DATA_B2_OUT(b),
      .pal_wr_index_load(load), .pal_wr_index(wr_index), .pal_wr_strobe(strobe),
      .pal_wr_data(wr_data), .pal_init_busy(busy), .pal_commit(commit),
      .pal_wr_index_out(idx_out)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic rd(input string tag, input logic [7:0] a, input logic [23:0] e);
      addr = a;
      exp_q.push_back(e);
      step();
      chk(tag, {8'h0, r, g, b}, {8'h0, exp_q.pop_front()});
   endtask
   task automatic load_idx(input logic [7:0] i);
      load = 1'b1;
      wr_index = i;
      step();
      load = 1'b0;
   endtask
   task automatic stb(input logic [7:0] d);
      strobe = 1'b1;
      wr_data = d;
      step();
      strobe = 1'b0;
   endtask
   // Run the init sweep to completion, optionally hammering CPU inputs meanwhile.
   task automatic sweep(input string tag, input logic hammer);
      int n = 0, c = 0;
      addr = 8'h37;
      strobe = hammer;
      load = hammer;
      wr_index = 8'h99;
      wr_data = 8'hEE;
      while (busy && n < 400) begin
         n++;
         step();
         if (commit) c++;
         if (n == 100) chk({tag, "_rgb_zero"}, {8'h0, r, g, b}, 32'h0);
      end
      strobe = 1'b0;
      load = 1'b0;
      chk({tag, "_busy_cycles"}, n, 256);
      chk({tag, "_commits"}, c, 256);
      step();
      chk({tag, "_commit_low"}, {31'h0, commit}, 32'h0);
      chk({tag, "_idx"}, {24'h0, idx_out}, 32'h0);
   endtask
   initial begin
      step();
      step();
      chk("rst_rgb", {8'h0, r, g, b}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h1);
      chk("rst_commit", {31'h0, commit}, 32'h0);
      chk("rst_idx", {24'h0, idx_out}, 32'h0);
      reset_n = 1'b1;
      sweep("init", 1'b0);
      rd("grey_5a", 8'h5A, 24'h5A5A5A);
      rd("grey_ff", 8'hFF, 24'hFFFFFF);
      load_idx(8'h10);
      stb(8'h11);
      stb(8'h22);
      chk("wr_no_early_commit", {31'h0, commit}, 32'h0);
      stb(8'h33);
      chk("wr_commit", {31'h0, commit}, 32'h1);
      chk("wr_idx", {24'h0, idx_out}, 32'h11);
      rd("wr_read", 8'h10, 24'h112233);
      chk("wr_commit_single", {31'h0, commit}, 32'h0);
      load_idx(8'hFF);
      stb(8'hA1); stb(8'hA2); stb(8'hA3);
      stb(8'hB1); stb(8'hB2); stb(8'hB3);
      chk("wrap_idx", {24'h0, idx_out}, 32'h01);
      rd("wrap_ff", 8'hFF, 24'hA1A2A3);
      rd("wrap_00", 8'h00, 24'hB1B2B3);
      rd("wrap_01", 8'h01, 24'h010101);
      load_idx(8'h20);
      stb(8'hC1);
      stb(8'hC2);
      strobe = 1'b1;
      wr_data = 8'hC3;
      rd("coll_old", 8'h20, 24'h202020);
      strobe = 1'b0;
      rd("coll_new", 8'h20, 24'hC1C2C3);
      stb(8'hAA);
      load = 1'b1;
      wr_index = 8'h40;
      strobe = 1'b1;
      wr_data = 8'h77;
      step();
      load = 1'b0;
      strobe = 1'b0;
      stb(8'h01);
      stb(8'h02);
      stb(8'h03);
      chk("prio_idx", {24'h0, idx_out}, 32'h41);
      rd("prio_40", 8'h40, 24'h010203);
      rd("prio_41", 8'h41, 24'h414141);
      load_idx(8'h80);
      stb(8'h55);
      stb(8'h66);
      reset_n = 1'b0;
      #2;
      chk("mid_rst_busy", {31'h0, busy}, 32'h1);
      chk("mid_rst_idx", {24'h0, idx_out}, 32'h0);
      step();
      reset_n = 1'b1;
      sweep("reinit", 1'b1);
      stb(8'hD1);
      stb(8'hD2);
      chk("phase_r_no_commit", {31'h0, commit}, 32'h0);
      stb(8'hD3);
      chk("phase_r_commit", {31'h0, commit}, 32'h1);
      chk("phase_r_idx", {24'h0, idx_out}, 32'h01);
      rd("reinit_00", 8'h00, 24'hD1D2D3);
      rd("reinit_80", 8'h80, 24'h808080);
      rd("reinit_99", 8'h99, 24'h999999);
      rd("reinit_10", 8'h10, 24'h101010);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
